// File: rtl/spi_pkg.sv
// Shared SPI frame constants, arbiter state encoding and small helpers.
// Latency: none (package only).
// Backpressure: none (package only).
package spi_pkg;

    localparam int SPI_WORD_W  = 8;
    localparam int SPI_N_WORDS = 4;
    localparam int SPI_FRAME_W = SPI_WORD_W * SPI_N_WORDS;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LAUNCH     = 3'd1,
        WAIT_START = 3'd2,
        WAIT_END   = 3'd3,
        COMPLETE   = 3'd4
    } arb_state_t;

    // 8-bit saturating increment used by the phase counter
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/spi_arbiter_if.sv
// Client-side and controller-side signal bundle of the SPI arbiter.
// Latency: none (wiring only).
// Backpressure: clients hold req until their done pulse.
interface spi_arbiter_if
    import spi_pkg::*;
#(
    parameter int N_REQ = 4
);

    logic [N_REQ-1:0]             req;
    logic [N_REQ*SPI_FRAME_W-1:0] tx_data;
    logic [N_REQ-1:0]             gnt;
    logic [N_REQ-1:0]             done;
    logic                         err;
    logic [SPI_FRAME_W-1:0]       rx_data;
    logic                         busy;
    logic                         spi_ctrl_en;
    logic [SPI_FRAME_W-1:0]       spi_tx;
    logic                         spi_ss;
    logic [SPI_FRAME_W-1:0]       spi_rx;

    // arbiter side
    modport slave (
        input  req, tx_data, spi_ss, spi_rx,
        output gnt, done, err, rx_data, busy, spi_ctrl_en, spi_tx
    );

    // clients plus controller side
    modport master (
        output req, tx_data, spi_ss, spi_rx,
        input  gnt, done, err, rx_data, busy, spi_ctrl_en, spi_tx
    );

endinterface

// File: rtl/spi_rr_picker.sv
// Round-robin picker: first set request searching upward from ptr+1 with wrap.
// Latency: combinational.
// Backpressure: none; pick is all-zero when no request is set.
module spi_rr_picker #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] pick,
    output logic [IDX_W-1:0] idx
);

    // rotate the search start just past the last winner
    always_comb begin
        logic found;
        int   j;
        pick  = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            j = (int'(ptr) + i) % N_REQ;
            if (!found && req[j]) begin
                found   = 1'b1;
                pick[j] = 1'b1;
                idx     = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/spi_arbiter.sv
// Round-robin arbiter/sequencer sharing one spi_controller between N_REQ clients.
// Latency: gnt and ctrl_en one cycle after req; done one cycle after SS rises or on timeout.
// Backpressure: req is level-held; losing clients wait in IDLE until the running frame completes.
module spi_arbiter
    import spi_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int START_WAIT  = 8,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic         clk,
    input  logic         n_rst,
    spi_arbiter_if.slave bus
);

    localparam int                IDX_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [IDX_W-1:0]  PTR_RST   = IDX_W'(N_REQ - 1);
    localparam logic [7:0]        START_LIM = 8'(START_WAIT);
    localparam logic [7:0]        END_LIM   = 8'(TIMEOUT_CYC);

    arb_state_t             state_q, state_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [N_REQ-1:0]       gnt_q, gnt_d;
    logic [N_REQ-1:0]       done_q, done_d;
    logic                   err_q, err_d;
    logic                   busy_q, busy_d;
    logic                   en_q, en_d;
    logic [SPI_FRAME_W-1:0] spi_tx_q, spi_tx_d;
    logic [SPI_FRAME_W-1:0] rx_data_q, rx_data_d;

    logic [N_REQ-1:0]       pick;
    logic [IDX_W-1:0]       pick_idx;
    logic [SPI_FRAME_W-1:0] tx_sel;
    logic [7:0]             cnt_inc;
    logic                   tout;

    spi_rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req  (bus.req),
        .ptr  (ptr_q),
        .pick (pick),
        .idx  (pick_idx)
    );

    // mux the winning client's frame; pick is one-hot so an OR of masked slices suffices
    always_comb begin
        tx_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            tx_sel = tx_sel | (bus.tx_data[i*SPI_FRAME_W +: SPI_FRAME_W] & {SPI_FRAME_W{pick[i]}});
        end
    end

    // sequencing FSM: grant, launch, follow SS, complete; counter restarts on every state change
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        idx_d     = idx_q;
        ptr_d     = ptr_q;
        spi_tx_d  = spi_tx_q;
        rx_data_d = rx_data_q;
        done_d    = '0;
        err_d     = 1'b0;
        en_d      = 1'b0;
        tout      = 1'b0;
        cnt_inc   = sat_inc8(cnt_q);

        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    state_d  = LAUNCH;
                    gnt_d    = pick;
                    idx_d    = pick_idx;
                    spi_tx_d = tx_sel;
                    en_d     = 1'b1;
                end
            end
            LAUNCH: begin
                state_d = WAIT_START;
            end
            WAIT_START: begin
                if (!bus.spi_ss) begin
                    state_d = WAIT_END;
                end else if (cnt_inc == START_LIM) begin
                    state_d = COMPLETE;
                    tout    = 1'b1;
                end
            end
            WAIT_END: begin
                if (bus.spi_ss) begin
                    state_d = COMPLETE;
                end else if (cnt_inc == END_LIM) begin
                    state_d = COMPLETE;
                    tout    = 1'b1;
                end
            end
            COMPLETE: begin
                state_d = IDLE;
                gnt_d   = '0;
                ptr_d   = idx_q;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase

        // done/err/rx are produced on the edge that enters COMPLETE, timeout or not
        if (state_q != COMPLETE && state_d == COMPLETE) begin
            done_d    = gnt_q;
            err_d     = tout;
            rx_data_d = bus.spi_rx;
        end

        cnt_d  = (state_d != state_q) ? 8'd0 : cnt_inc;
        busy_d = (state_d != IDLE);
    end

    // state and output registers; reset aborts any frame without a done pulse
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= IDLE;
            cnt_q     <= 8'd0;
            ptr_q     <= PTR_RST;
            idx_q     <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            en_q      <= 1'b0;
            spi_tx_q  <= '0;
            rx_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            en_q      <= en_d;
            spi_tx_q  <= spi_tx_d;
            rx_data_q <= rx_data_d;
        end
    end

    assign bus.gnt         = gnt_q;
    assign bus.done        = done_q;
    assign bus.err         = err_q;
    assign bus.busy        = busy_q;
    assign bus.spi_ctrl_en = en_q;
    assign bus.spi_tx      = spi_tx_q;
    assign bus.rx_data     = rx_data_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// Bench for spi_arbiter with a behavioural SS/MISO model and an expected-result queue.
// Latency: n/a.
// Backpressure: n/a.
module tb_spi_arbiter;
    import spi_pkg::*;

    localparam int N  = 4;
    localparam int SW = 8;
    localparam int TC = 255;

    typedef struct { int idx; logic [31:0] rx; logic err; } exp_t;
    typedef struct { logic [N-1:0] done; logic [N-1:0] gnt; logic [31:0] rx; logic err; } obs_t;

    logic clk;
    logic n_rst;

    spi_arbiter_if #(.N_REQ(N)) bus ();

    spi_arbiter #(
        .N_REQ       (N),
        .START_WAIT  (SW),
        .TIMEOUT_CYC (TC)
    ) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    exp_t        sb[$];
    obs_t        obs[$];
    logic [31:0] miso_q[$];
    int          miso_idx    = 0;
    bit          model_stuck = 0;
    int          model_dly   = 3;
    int          model_len   = 40;
    logic [31:0] rx_hold     = '0;
    int          ss_rise_cyc = 0;

    int gnt_log[$];
    int en_cnt      = 0;
    int en_cyc      = 0;
    int en_wide     = 0;
    int spacing_bad = 0;
    int done_cnt    = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // controller model: SS drops model_dly cycles after ctrl_en, rises model_len later with MISO frame
    initial begin
        bus.spi_ss = 1'b1;
        bus.spi_rx = '0;
        forever begin
            @(negedge clk);
            bus.spi_rx = rx_hold;
            if (bus.spi_ctrl_en === 1'b1 && !model_stuck) begin
                repeat (model_dly) @(negedge clk);
                bus.spi_ss = 1'b0;
                repeat (model_len) @(negedge clk);
                bus.spi_rx = (miso_idx < miso_q.size()) ? miso_q[miso_idx] : 32'h0;
                miso_idx++;
                bus.spi_ss  = 1'b1;
                ss_rise_cyc = cyc;
            end
        end
    end

    // passive monitor: grant order, ctrl_en pulse shape/spacing, done records
    initial begin
        logic [N-1:0] prev_gnt;
        logic         prev_en;
        bit           idle_seen;
        obs_t         o;
        prev_gnt  = '0;
        prev_en   = 1'b0;
        idle_seen = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.busy !== 1'b1) idle_seen = 1'b1;
            if (bus.spi_ctrl_en === 1'b1) begin
                if (prev_en) en_wide++;
                else begin
                    if (en_cnt > 0 && !idle_seen) spacing_bad++;
                    en_cnt++;
                    en_cyc    = cyc;
                    idle_seen = 1'b0;
                end
            end
            if (bus.gnt !== '0 && prev_gnt === '0)
                for (int i = 0; i < N; i++) if (bus.gnt[i] === 1'b1) gnt_log.push_back(i);
            if (|bus.done) begin
                done_cnt++;
                o.done = bus.done;
                o.gnt  = bus.gnt;
                o.rx   = bus.rx_data;
                o.err  = bus.err;
                obs.push_back(o);
            end
            prev_gnt = bus.gnt;
            prev_en  = bus.spi_ctrl_en;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish, got time %0t want under 500000", $time);
        $fatal(1, "watchdog");
    end

    task automatic expect_txn(input int idx, input logic [31:0] rx, input logic err, input bit via_miso);
        exp_t e;
        e.idx = idx;
        e.rx  = rx;
        e.err = err;
        sb.push_back(e);
        if (via_miso) miso_q.push_back(rx);
    endtask

    task automatic wait_done(input int budget, output logic [N-1:0] d, output bit ok);
        ok = 1'b0;
        d  = '0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (|bus.done) begin
                d  = bus.done;
                ok = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        n_rst       = 1'b0;
        bus.req     = '0;
        bus.tx_data = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.gnt !== '0 || bus.done !== '0) begin
            errors++; $display("FAIL reset_gnt_done got gnt=%b done=%b want 0", bus.gnt, bus.done);
        end
        checks++;
        if ({bus.err, bus.busy, bus.spi_ctrl_en} !== 3'b000) begin
            errors++; $display("FAIL reset_flags got err/busy/en=%b want 000", {bus.err, bus.busy, bus.spi_ctrl_en});
        end
        checks++;
        if (bus.rx_data !== '0) begin
            errors++; $display("FAIL reset_rx got %h want 0", bus.rx_data);
        end
        checks++;
        if (bus.spi_tx !== '0) begin
            errors++; $display("FAIL reset_tx got %h want 0", bus.spi_tx);
        end
        n_rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.spi_ctrl_en !== 1'b0) begin
            errors++; $display("FAIL idle_no_req got busy=%b en=%b want 0 0", bus.busy, bus.spi_ctrl_en);
        end
    endtask

    task automatic test_single();
        logic [N-1:0] d;
        bit ok;
        bus.tx_data[63:32] = 32'hFEFCFBFA;
        expect_txn(1, 32'hFAFBFCFE, 1'b0, 1'b1);
        bus.req = 4'b0010;
        @(negedge clk);
        checks++;
        if (bus.gnt !== 4'b0010) begin
            errors++; $display("FAIL single_gnt got %b want 0010", bus.gnt);
        end
        checks++;
        if (bus.spi_ctrl_en !== 1'b1) begin
            errors++; $display("FAIL single_en_rise got %b want 1", bus.spi_ctrl_en);
        end
        checks++;
        if (bus.spi_tx !== 32'hFEFCFBFA) begin
            errors++; $display("FAIL single_tx got %h want FEFCFBFA", bus.spi_tx);
        end
        @(negedge clk);
        checks++;
        if (bus.spi_ctrl_en !== 1'b0) begin
            errors++; $display("FAIL single_en_width got %b want 0", bus.spi_ctrl_en);
        end
        wait_done(300, d, ok);
        checks++;
        if (!ok || d !== 4'b0010) begin
            errors++; $display("FAIL single_done got ok=%0d done=%b want 1 0010", ok, d);
        end
        checks++;
        if (cyc - ss_rise_cyc != 1) begin
            errors++; $display("FAIL single_done_lat got %0d want 1", cyc - ss_rise_cyc);
        end
        checks++;
        if (bus.rx_data !== 32'hFAFBFCFE || bus.err !== 1'b0) begin
            errors++; $display("FAIL single_rx got rx=%h err=%b want FAFBFCFE 0", bus.rx_data, bus.err);
        end
        bus.req = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.gnt !== '0 || bus.busy !== 1'b0 || bus.rx_data !== 32'hFAFBFCFE || bus.spi_tx !== 32'hFEFCFBFA) begin
            errors++; $display("FAIL single_after got gnt=%b busy=%b rx=%h tx=%h want 0 0 FAFBFCFE FEFCFBFA",
                               bus.gnt, bus.busy, bus.rx_data, bus.spi_tx);
        end
    endtask

    task automatic test_all_four();
        logic [N-1:0] d;
        bit ok;
        int base_en, base_log, base_wide, base_sp, base_done;
        n_rst   = 1'b0;
        bus.req = 4'b1111;
        for (int k = 0; k < N; k++) begin
            bus.tx_data[k*32 +: 32] = 32'h1000_0000 + k;
            expect_txn(k, 32'hB0B0_0000 + k, 1'b0, 1'b1);
        end
        base_en   = en_cnt;
        base_log  = gnt_log.size();
        base_wide = en_wide;
        base_sp   = spacing_bad;
        base_done = done_cnt;
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        for (int n = 0; n < N; n++) begin
            wait_done(300, d, ok);
            checks++;
            if (!ok) begin
                errors++; $display("FAIL all4_timeout got no done want done #%0d", n);
            end
            bus.req = bus.req & ~d;
        end
        repeat (4) @(negedge clk);
        checks++;
        if (gnt_log.size() - base_log != 4) begin
            errors++; $display("FAIL all4_grants got %0d grants want 4", gnt_log.size() - base_log);
        end else begin
            for (int n = 0; n < N; n++) begin
                checks++;
                if (gnt_log[base_log + n] != n) begin
                    errors++; $display("FAIL all4_order got %0d want %0d", gnt_log[base_log + n], n);
                end
            end
        end
        checks++;
        if (en_cnt - base_en != 4 || en_wide != base_wide || spacing_bad != base_sp || done_cnt - base_done != 4) begin
            errors++; $display("FAIL all4_en got pulses=%0d wide=%0d spacing=%0d dones=%0d want 4 0 0 4",
                               en_cnt - base_en, en_wide - base_wide, spacing_bad - base_sp, done_cnt - base_done);
        end
    endtask

    task automatic test_alternate();
        logic [N-1:0] d;
        bit ok;
        int base_log;
        base_log = gnt_log.size();
        for (int n = 0; n < 6; n++) expect_txn((n % 2) * 2, 32'hA000_0000 + n, 1'b0, 1'b1);
        bus.req = 4'b0101;
        for (int n = 0; n < 6; n++) begin
            wait_done(300, d, ok);
            checks++;
            if (!ok) begin
                errors++; $display("FAIL alt_timeout got no done want done #%0d", n);
            end
        end
        bus.req = '0;
        repeat (4) @(negedge clk);
        checks++;
        if (gnt_log.size() - base_log != 6) begin
            errors++; $display("FAIL alt_grants got %0d want 6", gnt_log.size() - base_log);
        end else begin
            for (int n = 0; n < 6; n++) begin
                checks++;
                if (gnt_log[base_log + n] != (n % 2) * 2) begin
                    errors++; $display("FAIL alt_order got %0d want %0d", gnt_log[base_log + n], (n % 2) * 2);
                end
            end
        end
    endtask

    task automatic test_timeout();
        logic [N-1:0] d;
        bit ok;
        model_stuck = 1'b1;
        rx_hold     = 32'h13572468;
        expect_txn(3, 32'h13572468, 1'b1, 1'b0);
        bus.tx_data[127:96] = 32'h33333333;
        bus.req = 4'b1000;
        wait_done(100, d, ok);
        checks++;
        if (!ok || d !== 4'b1000) begin
            errors++; $display("FAIL tout_done got ok=%0d done=%b want 1 1000", ok, d);
        end
        checks++;
        if (bus.err !== 1'b1) begin
            errors++; $display("FAIL tout_err got %b want 1", bus.err);
        end
        checks++;
        if (cyc - en_cyc != SW + 1) begin
            errors++; $display("FAIL tout_lat got %0d want %0d", cyc - en_cyc, SW + 1);
        end
        bus.req     = '0;
        model_stuck = 1'b0;
        rx_hold     = '0;
        repeat (2) @(negedge clk);
        expect_txn(0, 32'hC0C0C0C1, 1'b0, 1'b1);
        bus.req = 4'b0001;
        wait_done(300, d, ok);
        checks++;
        if (!ok || d !== 4'b0001 || bus.err !== 1'b0) begin
            errors++; $display("FAIL tout_next got ok=%0d done=%b err=%b want 1 0001 0", ok, d, bus.err);
        end
        bus.req = '0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] d;
        bit ok;
        int base_done, base_log;
        model_len = 60;
        miso_q.push_back(32'h0BAD0BAD);
        bus.tx_data[95:64] = 32'h22222222;
        bus.req = 4'b0100;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (bus.spi_ss === 1'b0) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            errors++; $display("FAIL rstmid_ss got ss=%b want 0", bus.spi_ss);
        end
        repeat (10) @(negedge clk);
        base_done = done_cnt;
        n_rst = 1'b0;
        #1;
        checks++;
        if (bus.gnt !== '0 || bus.done !== '0 || bus.err !== 1'b0 || bus.busy !== 1'b0 ||
            bus.spi_ctrl_en !== 1'b0 || bus.rx_data !== '0 || bus.spi_tx !== '0) begin
            errors++; $display("FAIL rstmid_outs got gnt=%b done=%b err=%b busy=%b en=%b rx=%h tx=%h want all 0",
                               bus.gnt, bus.done, bus.err, bus.busy, bus.spi_ctrl_en, bus.rx_data, bus.spi_tx);
        end
        bus.req = 4'b1010;
        repeat (70) @(negedge clk);
        checks++;
        if (done_cnt != base_done) begin
            errors++; $display("FAIL rstmid_nodone got %0d pulses want 0", done_cnt - base_done);
        end
        model_len = 40;
        base_log  = gnt_log.size();
        expect_txn(1, 32'hD1D1D1D1, 1'b0, 1'b1);
        expect_txn(3, 32'hD3D3D3D3, 1'b0, 1'b1);
        n_rst = 1'b1;
        for (int n = 0; n < 2; n++) begin
            wait_done(300, d, ok);
            checks++;
            if (!ok) begin
                errors++; $display("FAIL rstmid_timeout got no done want done #%0d", n);
            end
            bus.req = bus.req & ~d;
        end
        repeat (3) @(negedge clk);
        checks++;
        if (gnt_log.size() - base_log != 2 || gnt_log[base_log] != 1 || gnt_log[base_log + 1] != 3) begin
            errors++; $display("FAIL rstmid_order got %0d grants first=%0d want 2 grants 1 then 3",
                               gnt_log.size() - base_log, (gnt_log.size() > base_log) ? gnt_log[base_log] : -1);
        end
    endtask

    task automatic test_drop_after_grant();
        logic [N-1:0] d;
        bit ok;
        expect_txn(2, 32'hCAFEF00D, 1'b0, 1'b1);
        bus.tx_data[95:64] = 32'h12345678;
        bus.req = 4'b0100;
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            if (bus.gnt === 4'b0100) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            errors++; $display("FAIL drop_gnt got %b want 0100", bus.gnt);
        end
        @(negedge clk);
        bus.req = '0;
        wait_done(300, d, ok);
        checks++;
        if (!ok || d !== 4'b0100) begin
            errors++; $display("FAIL drop_done got ok=%0d done=%b want 1 0100", ok, d);
        end
        checks++;
        if (bus.rx_data !== 32'hCAFEF00D) begin
            errors++; $display("FAIL drop_rx got %h want CAFEF00D", bus.rx_data);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_scoreboard();
        int n;
        logic [N-1:0] one;
        logic [N-1:0] want;
        one = 1;
        checks++;
        if (obs.size() != sb.size()) begin
            errors++; $display("FAIL sb_count got %0d done pulses want %0d", obs.size(), sb.size());
        end
        n = (obs.size() < sb.size()) ? obs.size() : sb.size();
        for (int i = 0; i < n; i++) begin
            want = one << sb[i].idx;
            checks++;
            if (obs[i].done !== want || obs[i].gnt !== want || obs[i].rx !== sb[i].rx || obs[i].err !== sb[i].err) begin
                errors++;
                $display("FAIL sb_txn%0d got done=%b gnt=%b rx=%h err=%b want done=%b gnt=%b rx=%h err=%b",
                         i, obs[i].done, obs[i].gnt, obs[i].rx, obs[i].err, want, want, sb[i].rx, sb[i].err);
            end
        end
    endtask

    initial begin
        n_rst       = 1'b0;
        bus.req     = '0;
        bus.tx_data = '0;
        test_reset();
        test_single();
        test_all_four();
        test_alternate();
        test_timeout();
        test_reset_mid();
        test_drop_after_grant();
        test_scoreboard();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_arbiter.md
Name: spi_arbiter

Overview:
Round-robin arbiter and sequencer that shares one spi_controller between N_REQ requesters.
- Grants a requester and latches its 32-bit frame onto the controller word inputs.
- Issues the single-cycle ctrl_en start pulse.
- Tracks the transfer through SS, captures the 32-bit received frame and returns it with a done pulse.
- Sits between system-side clients and the spi_controller instance; the controller shares clk/n_rst.

Parameters:
N_REQ, 4, number of requesters (2..8)
START_WAIT, 8, max cycles from ctrl_en pulse to SS falling before timeout
TIMEOUT_CYC, 255, max cycles with SS low before timeout (nominal 32-bit frame at SCK=clk/2 is ~64 cycles)

Ports:
clk  in  1  system clock, all logic on rising edge
n_rst  in  1  asynchronous active-low reset
req  in  N_REQ  request per client, held until its done
tx_data  in  N_REQ*32  client i frame at [32i+31:32i]; bits [7:0] go to word_0_in, [31:24] to word_3_in
gnt  out  N_REQ  one-hot grant, high from grant until done cycle inclusive
done  out  N_REQ  one-cycle completion pulse to the granted client
err  out  1  one-cycle pulse coincident with done when the transaction timed out
rx_data  out  32  received frame {word_3_out,word_2_out,word_1_out,word_0_out}; valid with done, held until next done
busy  out  1  high whenever state != IDLE
spi_ctrl_en  out  1  start pulse to spi_controller.ctrl_en
spi_tx  out  32  to {word_3_in..word_0_in}
spi_ss  in  1  spi_controller.SS (low = transfer in progress)
spi_rx  in  32  from {word_3_out..word_0_out}

Behaviour:
- Reset (async, n_rst=0): gnt=0, done=0, err=0, rx_data=0, busy=0, spi_ctrl_en=0, spi_tx=0, state=IDLE, counter=0, last-grant pointer=N_REQ-1 so req[0] wins first. Reset mid-transaction aborts with no done pulse.
- All outputs are registered.
- FSM states: IDLE, LAUNCH, WAIT_START, WAIT_END, COMPLETE.
- IDLE:
  - If req!=0 at edge N, pick the first set bit searching from pointer+1 with wrap.
  - At N+1: gnt[k]=1, spi_tx=tx_data slice k (sampled once at edge N), state LAUNCH.
- LAUNCH: spi_ctrl_en=1 for exactly this one cycle; counter cleared; next state WAIT_START.
- WAIT_START:
  - spi_ss==0 → WAIT_END, counter cleared.
  - counter reaches START_WAIT → COMPLETE with timeout flag set.
- WAIT_END:
  - spi_ss==1 → COMPLETE.
  - counter reaches TIMEOUT_CYC → COMPLETE with timeout flag set.
- COMPLETE (one cycle):
  - done[k]=1; rx_data<=spi_rx captured on entry edge, captured even on timeout.
  - err=timeout flag; pointer<=k; gnt cleared at the following edge; next state IDLE.
- Minimum one IDLE cycle between transactions, so spi_ctrl_en is never back-to-back.
- spi_tx is held constant from LAUNCH through COMPLETE.
- Dropping req[k] after grant does not abort; done[k] still pulses.
- A new req arriving during a transfer waits in IDLE arbitration.
- Counter is 8-bit saturating and cleared on every state change.

Decomposition:
- Shared package spi_pkg:
  - SPI_WORD_W=8, SPI_N_WORDS=4, SPI_FRAME_W=32.
  - typedef enum arb_state_t {IDLE, LAUNCH, WAIT_START, WAIT_END, COMPLETE}.
- Sub-module spi_rr_picker: combinational, inputs req and pointer, outputs one-hot pick and index.
- FSM, counter and data registers stay in spi_arbiter.

Test Plan:
1. After reset, req=4'b0010, tx_data slice1=32'hFEFCFBFA, real spi_controller plus slave model driving MISO 32'hFAFBFCFE:
   - gnt=4'b0010 one cycle after req.
   - spi_ctrl_en exactly one cycle.
   - MOSI bytes FA,FB,FC,FE.
   - done[1] one cycle after SS rises, rx_data=32'hFAFBFCFE, err=0.
2. req=4'b1111 held from reset, each dropped after its done:
   - Grants in order 0,1,2,3, each done once.
   - spi_ctrl_en pulses exactly 4 times, each separated by ≥1 IDLE cycle.
3. req=4'b0101 held continuously for 6 transactions: grants alternate 0,2,0,2,0,2.
4. spi_ss stubbed constantly high, req[3]:
   - done[3] and err both pulse START_WAIT+1 cycles after the spi_ctrl_en pulse.
   - A following req[0] is then served normally with err=0.
5. n_rst low 10 cycles into WAIT_END:
   - All outputs 0 immediately, no done pulse.
   - After release, req=4'b1010 grants client 1 first (pointer reset).
6. req[2] dropped the cycle after gnt[2] rises: transaction completes, done[2] pulses, rx_data updated.
